// File: rtl/div_stream_ctrl.sv
// Valid/ready front-end for the iterative long divider: request FIFO, one-at-a-time issue, held result register.
// Optional build macro DIV_STREAM_DBZ_BYPASS_EN answers zero-divisor requests locally without using the divider.
module div_stream_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    output logic             o_div_start,
    output logic [WIDTH-1:0] o_div_a,
    output logic [WIDTH-1:0] o_div_b,
    input  logic             i_div_done,
    input  logic             i_div_dbz,
    input  logic [WIDTH-1:0] i_div_quot,
    input  logic [WIDTH-1:0] i_div_rem,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_quot,
    output logic [WIDTH-1:0] m_rem,
    output logic             m_dbz
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // IDLE: wait for request and free slot | ISSUE: start pulse (or bypass capture) | WAIT: divider busy
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, capture, empty, slot_free;
    logic             head_zero, byp_pend;
    logic [WIDTH-1:0] byp_a;

    assign s_ready   = (count != FULL_CNT);
    assign empty     = (count == '0);
    assign push      = s_valid && s_ready;
    assign slot_free = !m_valid || m_ready;

`ifdef DIV_STREAM_DBZ_BYPASS_EN
    assign head_zero = (mem_b[rd_ptr] == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byp_pend <= 1'b0;
            byp_a    <= '0;
        end else if (pop) begin
            byp_pend <= head_zero;
            byp_a    <= mem_a[rd_ptr];
        end
    end
`else
    assign head_zero = 1'b0;
    assign byp_pend  = 1'b0;
    assign byp_a     = '0;
`endif

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        o_div_start = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && slot_free) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_div_start = !byp_pend;
                capture     = byp_pend;
                state_nxt   = byp_pend ? IDLE : WAIT;
            end
            WAIT: begin
                if (i_div_done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_a[wr_ptr] <= s_a;
            mem_b[wr_ptr] <= s_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_div_a <= '0;
            o_div_b <= '0;
            m_valid <= 1'b0;
            m_quot  <= '0;
            m_rem   <= '0;
            m_dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            if (pop && !head_zero) begin
                o_div_a <= mem_a[rd_ptr];
                o_div_b <= mem_b[rd_ptr];
            end
            // Issue gating keeps the slot empty when a capture lands, so capture simply wins.
            if (capture) begin
                m_valid <= 1'b1;
                m_quot  <= byp_pend ? '1 : i_div_quot;
                m_rem   <= byp_pend ? byp_a : i_div_rem;
                m_dbz   <= byp_pend | i_div_dbz;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
